// File: rtl/mem_arbiter_if.sv
// Client-side and memory-side buses of the shared memory arbiter.
// Handshake: a requester raises access and holds it with address/data/strobes stable until it sees a one-cycle ack.
interface mem_arbiter_if #(
  parameter int NUM_CHANNELS = 2
);
  logic [NUM_CHANNELS*19-1:0] c_m_addr;
  logic [NUM_CHANNELS*16-1:0] c_m_data_out;
  logic [NUM_CHANNELS-1:0]    c_m_wr_en;
  logic [NUM_CHANNELS*2-1:0]  c_m_bytesel;
  logic [NUM_CHANNELS-1:0]    c_m_access;
  logic [NUM_CHANNELS-1:0]    c_m_ack;
  logic [15:0]                c_m_data_in;

  logic [18:0]                q_m_addr;
  logic [15:0]                q_m_data_out;
  logic                       q_m_wr_en;
  logic [1:0]                 q_m_bytesel;
  logic                       q_m_access;
  logic                       q_m_ack;
  logic [15:0]                q_m_data_in;

  // The arbiter side: takes client requests and drives the memory port.
  modport slave (
    input  c_m_addr, c_m_data_out, c_m_wr_en, c_m_bytesel, c_m_access,
    input  q_m_ack, q_m_data_in,
    output c_m_ack, c_m_data_in,
    output q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access
  );

  // The surrounding system: clients plus the external memory.
  modport master (
    output c_m_addr, c_m_data_out, c_m_wr_en, c_m_bytesel, c_m_access,
    output q_m_ack, q_m_data_in,
    input  c_m_ack, c_m_data_in,
    input  q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter merging core memory masters onto one access/ack memory port.
// The grant is held for the whole transaction and every ack is followed by one IDLE cycle.
module mem_arbiter #(
  parameter  int NUM_CHANNELS = 2,
  parameter  int ROUND_ROBIN  = 1,
  localparam int GW = ($clog2(NUM_CHANNELS) > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [GW-1:0] grant_id,
  output logic          state_dbg
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CHANNELS - 1);

  state_t        state;
  state_t        state_n;
  logic [GW-1:0] grant_n;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] rr_ptr_n;

  logic [GW-1:0] winner;
  logic          any_req;
  logic          found;
  logic [GW:0]   scan_sum;
  logic [GW-1:0] scan;

  logic [18:0]   ch_addr  [NUM_CHANNELS];
  logic [15:0]   ch_wdata [NUM_CHANNELS];
  logic [1:0]    ch_bsel  [NUM_CHANNELS];

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch_addr[i]  = bus.c_m_addr[i*19 +: 19];
      ch_wdata[i] = bus.c_m_data_out[i*16 +: 16];
      ch_bsel[i]  = bus.c_m_bytesel[i*2 +: 2];
    end
  end

  // Round-robin scans upward from rr_ptr with wrap; fixed priority keeps the lowest index.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan     = '0;
    any_req  = |bus.c_m_access;
    if (ROUND_ROBIN != 0) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
        if (scan_sum >= (GW+1)'(NUM_CHANNELS)) begin
          scan_sum = scan_sum - (GW+1)'(NUM_CHANNELS);
        end
        scan = scan_sum[GW-1:0];
        if (!found && bus.c_m_access[scan]) begin
          winner = scan;
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
        if (bus.c_m_access[k]) begin
          winner = GW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      rr_ptr   <= rr_ptr_n;
    end
  end

  // A dropped access without an ack is a client abort: release the bus, keep rr_ptr.
  always_comb begin
    state_n  = state;
    grant_n  = grant_id;
    rr_ptr_n = rr_ptr;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_n = S_GRANTED;
          grant_n = winner;
        end
      end
      S_GRANTED: begin
        if (bus.q_m_ack) begin
          state_n  = S_IDLE;
          rr_ptr_n = (grant_id == LAST_CH) ? '0 : grant_id + GW'(1);
        end else if (!bus.c_m_access[grant_id]) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.q_m_access   = 1'b0;
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = '0;
    bus.c_m_ack      = '0;
    bus.c_m_data_in  = bus.q_m_data_in;
    if (state == S_GRANTED) begin
      bus.q_m_access        = bus.c_m_access[grant_id];
      bus.q_m_addr          = ch_addr[grant_id];
      bus.q_m_data_out      = ch_wdata[grant_id];
      bus.q_m_wr_en         = bus.c_m_wr_en[grant_id];
      bus.q_m_bytesel       = ch_bsel[grant_id];
      bus.c_m_ack[grant_id] = bus.q_m_ack;
    end
  end

  assign state_dbg = (state == S_GRANTED);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 3-channel round-robin and a 2-channel fixed-priority instance,
// directed scenarios followed by random traffic, all checked against a cycle-level reference model.
module tb_mem_arbiter;
  localparam int N0 = 3;
  localparam int N1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_CHANNELS(N0)) bus0 ();
  mem_arbiter_if #(.NUM_CHANNELS(N1)) bus1 ();
  logic [1:0] gid0;
  logic       gid1;
  logic       st0;
  logic       st1;

  mem_arbiter #(.NUM_CHANNELS(N0), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(rst), .bus(bus0), .grant_id(gid0), .state_dbg(st0)
  );
  mem_arbiter #(.NUM_CHANNELS(N1), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(rst), .bus(bus1), .grant_id(gid1), .state_dbg(st1)
  );

  // Stimulus arrays: [instance][channel].
  logic        t_acc  [2][3];
  logic [18:0] t_addr [2][3];
  logic [15:0] t_wd   [2][3];
  logic        t_wr   [2][3];
  logic [1:0]  t_bs   [2][3];
  logic        t_qack [2];
  logic [15:0] t_qd   [2];

  always_comb begin
    for (int i = 0; i < N0; i++) begin
      bus0.c_m_access[i]           = t_acc[0][i];
      bus0.c_m_addr[i*19 +: 19]    = t_addr[0][i];
      bus0.c_m_data_out[i*16 +: 16] = t_wd[0][i];
      bus0.c_m_wr_en[i]            = t_wr[0][i];
      bus0.c_m_bytesel[i*2 +: 2]   = t_bs[0][i];
    end
    bus0.q_m_ack     = t_qack[0];
    bus0.q_m_data_in = t_qd[0];
  end

  always_comb begin
    for (int i = 0; i < N1; i++) begin
      bus1.c_m_access[i]           = t_acc[1][i];
      bus1.c_m_addr[i*19 +: 19]    = t_addr[1][i];
      bus1.c_m_data_out[i*16 +: 16] = t_wd[1][i];
      bus1.c_m_wr_en[i]            = t_wr[1][i];
      bus1.c_m_bytesel[i*2 +: 2]   = t_bs[1][i];
    end
    bus1.q_m_ack     = t_qack[1];
    bus1.q_m_data_in = t_qd[1];
  end

  typedef struct {
    logic        acc;
    logic [18:0] addr;
    logic [15:0] wd;
    logic        wr;
    logic [1:0]  bs;
    logic [2:0]  ack;
    logic [15:0] rd;
    logic [31:0] gid;
    logic        st;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  obs_t last_obs [2];
  bit   mem_pend [2];
  int   ack_log [$];
  int   ack_cyc [$];

  // Reference model: busy flag, granted channel, next round-robin start channel.
  int nch  [2] = '{N0, N1};
  bit rrm  [2] = '{1'b1, 1'b0};
  bit m_busy [2];
  int m_gid  [2];
  int m_ptr  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int d);
    for (int k = 0; k < nch[d]; k++) begin
      int c;
      c = rrm[d] ? (m_ptr[d] + k) % nch[d] : k;
      if (t_acc[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.acc = bus0.q_m_access; o.addr = bus0.q_m_addr; o.wd = bus0.q_m_data_out;
      o.wr = bus0.q_m_wr_en; o.bs = bus0.q_m_bytesel; o.ack = bus0.c_m_ack;
      o.rd = bus0.c_m_data_in; o.gid = 32'(gid0); o.st = st0;
    end else begin
      o.acc = bus1.q_m_access; o.addr = bus1.q_m_addr; o.wd = bus1.q_m_data_out;
      o.wr = bus1.q_m_wr_en; o.bs = bus1.q_m_bytesel; o.ack = {1'b0, bus1.c_m_ack};
      o.rd = bus1.c_m_data_in; o.gid = 32'(gid1); o.st = st1;
    end
    return o;
  endfunction

  function automatic int onehot_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  // Compare both instances against the model, then advance the model across the coming edge.
  task automatic eval_cycle();
    obs_t       o;
    logic [2:0] e_ack;
    int         g;
    int         w;
    bit         b;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      g = m_gid[d];
      b = m_busy[d];
      e_ack = '0;
      if (b && t_qack[d]) e_ack[g] = 1'b1;
      chk($sformatf("d%0d_q_access", d), 32'(o.acc), 32'(b ? t_acc[d][g] : 1'b0));
      chk($sformatf("d%0d_q_addr", d), 32'(o.addr), 32'(b ? t_addr[d][g] : 19'h0));
      chk($sformatf("d%0d_q_data_out", d), 32'(o.wd), 32'(b ? t_wd[d][g] : 16'h0));
      chk($sformatf("d%0d_q_wr_en", d), 32'(o.wr), 32'(b ? t_wr[d][g] : 1'b0));
      chk($sformatf("d%0d_q_bytesel", d), 32'(o.bs), 32'(b ? t_bs[d][g] : 2'b00));
      chk($sformatf("d%0d_c_ack", d), 32'(o.ack), 32'(e_ack));
      chk($sformatf("d%0d_c_data_in", d), 32'(o.rd), 32'(t_qd[d]));
      chk($sformatf("d%0d_grant_id", d), o.gid, 32'(g));
      chk($sformatf("d%0d_state", d), 32'(o.st), 32'(b));
      last_obs[d] = o;
      if (rst) begin
        m_busy[d] = 1'b0; m_gid[d] = 0; m_ptr[d] = 0;
      end else if (!b) begin
        w = pick(d);
        if (w >= 0) begin m_busy[d] = 1'b1; m_gid[d] = w; end
      end else if (t_qack[d]) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = (g + 1) % nch[d];
      end else if (!t_acc[d][g]) begin
        m_busy[d] = 1'b0;
      end
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    eval_cycle();
    next_edge();
  endtask

  // Memory that acks one cycle after it sees an unacked access.
  task automatic auto_cycle(input int d);
    t_qack[d] = mem_pend[d];
    t_qd[d]   = 16'($urandom);
    eval_cycle();
    if (last_obs[d].ack != 3'b000) begin
      ack_log.push_back(onehot_idx(last_obs[d].ack));
      ack_cyc.push_back(cyc);
    end
    mem_pend[d] = last_obs[d].acc && !t_qack[d];
    next_edge();
  endtask

  task automatic wait_ack(input int d, input int max_cycles);
    ack_log.delete();
    ack_cyc.delete();
    for (int k = 0; k < max_cycles && ack_log.size() == 0; k++) auto_cycle(d);
    chk($sformatf("d%0d_ack_within_budget", d), 32'(ack_log.size()), 32'd1);
    t_qack[d]   = 1'b0;
    mem_pend[d] = 1'b0;
  endtask

  task automatic set_req(input int d, input int c, input logic [18:0] a, input logic [15:0] w,
                         input logic wr, input logic [1:0] bs);
    t_acc[d][c] = 1'b1; t_addr[d][c] = a; t_wd[d][c] = w; t_wr[d][c] = wr; t_bs[d][c] = bs;
  endtask

  task automatic clr_all();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        t_acc[d][c] = 1'b0; t_addr[d][c] = '0; t_wd[d][c] = '0; t_wr[d][c] = 1'b0; t_bs[d][c] = '0;
      end
      t_qack[d] = 1'b0; t_qd[d] = '0; mem_pend[d] = 1'b0;
    end
  endtask

  initial begin
    clr_all();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_gid[d] = 0; m_ptr[d] = 0;
    end

    // Reset
    rst = 1'b1;
    next_edge();
    eval_cycle();
    chk("reset_gid0", 32'(gid0), 32'd0);
    chk("reset_q_access1", 32'(bus1.q_m_access), 32'd0);
    chk("reset_ack0", 32'(bus0.c_m_ack), 32'd0);
    next_edge();
    rst = 1'b0;

    // Single request on the 2-channel instance
    set_req(1, 1, 19'h12345, 16'h0000, 1'b0, 2'b11);
    tick();
    eval_cycle();
    chk("single_access_c1", 32'(last_obs[1].acc), 32'd1);
    chk("single_addr_c1", 32'(last_obs[1].addr), 32'h12345);
    next_edge();
    eval_cycle();
    chk("single_access_c2", 32'(last_obs[1].acc), 32'd1);
    next_edge();
    t_qack[1] = 1'b1; t_qd[1] = 16'hBEEF;
    eval_cycle();
    chk("single_ack_c3", 32'(last_obs[1].ack), 32'b010);
    chk("single_rdata_c3", 32'(last_obs[1].rd), 32'hBEEF);
    next_edge();
    t_qack[1] = 1'b0; t_acc[1][1] = 1'b0;
    eval_cycle();
    chk("single_access_c4", 32'(last_obs[1].acc), 32'd0);
    next_edge();

    // Round-robin fairness: channels 0 and 1 of the 3-channel instance request continuously
    ack_log.delete(); ack_cyc.delete();
    set_req(0, 0, 19'($urandom), 16'($urandom), 1'b0, 2'b11);
    set_req(0, 1, 19'($urandom), 16'($urandom), 1'b1, 2'b10);
    repeat (12) auto_cycle(0);
    chk("rr_ack_count", 32'(ack_log.size()), 32'd4);
    for (int k = 0; k < ack_log.size() && k < 4; k++)
      chk($sformatf("rr_grant_%0d", k), 32'(ack_log[k]), 32'(k % 2));
    for (int k = 1; k < ack_cyc.size(); k++)
      chk($sformatf("rr_spacing_%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
    t_acc[0][0] = 1'b0; t_acc[0][1] = 1'b0; t_qack[0] = 1'b0; mem_pend[0] = 1'b0;
    tick(); tick();

    // Fixed priority: both channels request, channel 0 always wins until it withdraws
    ack_log.delete(); ack_cyc.delete();
    set_req(1, 0, 19'($urandom), 16'($urandom), 1'b0, 2'b11);
    set_req(1, 1, 19'($urandom), 16'($urandom), 1'b0, 2'b11);
    repeat (12) auto_cycle(1);
    chk("fp_ack_count", 32'(ack_log.size()), 32'd4);
    for (int k = 0; k < ack_log.size(); k++)
      chk($sformatf("fp_grant_%0d", k), 32'(ack_log[k]), 32'd0);
    t_acc[1][0] = 1'b0; t_qack[1] = 1'b0; mem_pend[1] = 1'b0;
    tick();
    auto_cycle(1);
    chk("fp_ch1_gid", last_obs[1].gid, 32'd1);
    chk("fp_ch1_access", 32'(last_obs[1].acc), 32'd1);
    wait_ack(1, 4);
    t_acc[1][1] = 1'b0;
    tick(); tick();

    // Wrap-around: channel 2 served, then channels 0 and 2 compete
    set_req(0, 2, 19'($urandom), 16'($urandom), 1'b0, 2'b01);
    wait_ack(0, 10);
    chk("wrap_first", 32'(ack_log.size() == 1 ? ack_log[0] : -1), 32'd2);
    set_req(0, 0, 19'($urandom), 16'($urandom), 1'b1, 2'b11);
    tick();
    auto_cycle(0);
    chk("wrap_gid", last_obs[0].gid, 32'd0);
    wait_ack(0, 10);
    chk("wrap_acked", 32'(ack_log.size() == 1 ? ack_log[0] : -1), 32'd0);
    t_acc[0][0] = 1'b0; t_acc[0][2] = 1'b0;
    tick(); tick();

    // Reset mid-transaction, with a late memory ack afterwards
    set_req(0, 1, 19'($urandom), 16'($urandom), 1'b0, 2'b11);
    wait_ack(0, 10);
    tick();
    eval_cycle();
    chk("rstmid_pre_gid", last_obs[0].gid, 32'd1);
    chk("rstmid_pre_access", 32'(last_obs[0].acc), 32'd1);
    next_edge();
    rst = 1'b1; t_acc[0][1] = 1'b0;
    tick();
    rst = 1'b0;
    eval_cycle();
    chk("rstmid_access", 32'(last_obs[0].acc), 32'd0);
    chk("rstmid_gid", last_obs[0].gid, 32'd0);
    next_edge();
    t_qack[0] = 1'b1; t_qd[0] = 16'h1234;
    eval_cycle();
    chk("rstmid_late_ack", 32'(last_obs[0].ack), 32'd0);
    next_edge();
    t_qack[0] = 1'b0;
    set_req(0, 1, 19'($urandom), 16'($urandom), 1'b0, 2'b11);
    set_req(0, 2, 19'($urandom), 16'($urandom), 1'b0, 2'b11);
    tick();
    eval_cycle();
    chk("rstmid_ptr_cleared", last_obs[0].gid, 32'd1);
    next_edge();
    wait_ack(0, 10);
    t_acc[0][1] = 1'b0; t_acc[0][2] = 1'b0;
    tick(); tick();

    // Write path, then client abort
    set_req(1, 1, 19'h00ABC, 16'h00A5, 1'b1, 2'b01);
    tick();
    eval_cycle();
    chk("wr_en", 32'(last_obs[1].wr), 32'd1);
    chk("wr_bytesel", 32'(last_obs[1].bs), 32'b01);
    chk("wr_data", 32'(last_obs[1].wd), 32'h00A5);
    next_edge();
    t_acc[1][1] = 1'b0;
    eval_cycle();
    chk("abort_no_ack", 32'(last_obs[1].ack), 32'd0);
    next_edge();
    eval_cycle();
    chk("abort_idle", 32'(last_obs[1].st), 32'd0);
    chk("abort_wr_low", 32'(last_obs[1].wr), 32'd0);
    chk("abort_access_low", 32'(last_obs[1].acc), 32'd0);
    next_edge();
    clr_all();
    tick();

    // Random traffic: clients hold until acked (rare aborts), memory acks at random, also while idle
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < nch[d]; c++) begin
          if (t_acc[d][c]) begin
            if (last_obs[d].ack[c] === 1'b1) t_acc[d][c] = 1'b0;
            else if ($urandom_range(0, 49) == 0) t_acc[d][c] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            set_req(d, c, 19'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
          end
        end
        t_qack[d] = ($urandom_range(0, 2) == 0);
        t_qd[d]   = 16'($urandom);
      end
      tick();
    end
    clr_all();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
